// File: rtl/cpu_ctrl_fsm.sv
// Accumulator-CPU sequencer: 8-phase fetch/decode/execute, HALTED parking; CTRL_SINGLE_STEP_EN adds step hold in S7.
// Outputs combinational from state/opcode/zero, one phase per clk; ena=0 idles to S0 (no backpressure otherwise).
module cpu_ctrl_fsm #(
    parameter int HALT_STICKY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       alu_en,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt,
    output logic [3:0] state
);

    localparam logic [3:0] S0     = 4'd0;
    localparam logic [3:0] S1     = 4'd1;
    localparam logic [3:0] S2     = 4'd2;
    localparam logic [3:0] S3     = 4'd3;
    localparam logic [3:0] S4     = 4'd4;
    localparam logic [3:0] S5     = 4'd5;
    localparam logic [3:0] S6     = 4'd6;
    localparam logic [3:0] S7     = 4'd7;
    localparam logic [3:0] HALTED = 4'd8;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    logic active;
    logic wrap_ok;
    logic is_alu_op;

`ifdef CTRL_SINGLE_STEP_EN
    assign wrap_ok = step;
`else
    assign wrap_ok = 1'b1;
`endif

    assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                       (opcode == OP_XORR) || (opcode == OP_LDA);

    // The arming edge only sets active, so S0 is presented for a full cycle
    // before the first fetch advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S0;
            active <= 1'b0;
        end else if (state == HALTED) begin
            state  <= HALTED;
        end else if (!ena) begin
            state  <= S0;
            active <= 1'b0;
        end else if (!active) begin
            active <= 1'b1;
        end else begin
            case (state)
                S3:      state <= ((opcode == OP_HLT) && (HALT_STICKY != 0)) ? HALTED : S4;
                S7:      state <= wrap_ok ? S0 : S7;
                default: state <= state + 4'd1;
            endcase
        end
    end

    always_comb begin
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        alu_en      = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        if (state == HALTED) begin
            halt = 1'b1;
        end else if (active) begin
            case (state)
                S0, S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S3: halt = (opcode == OP_HLT);
                S4: begin
                    load_pc     = (opcode == OP_JMP);
                    rd          = is_alu_op;
                    alu_en      = is_alu_op;
                    datactl_ena = (opcode == OP_STO);
                end
                S5: begin
                    rd          = is_alu_op;
                    load_acc    = is_alu_op;
                    datactl_ena = (opcode == OP_STO);
                    wr          = (opcode == OP_STO);
                    inc_pc      = (opcode == OP_SKZ) && zero;
                end
                S6: begin
                    datactl_ena = (opcode == OP_STO);
                    inc_pc      = (opcode == OP_SKZ) && zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus pushes hand-written expected vectors, negedge monitor pops and compares.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       step;
    logic [2:0] opcode;
    logic       zero;
    logic       load_ir, inc_pc, load_pc, rd, wr, alu_en, load_acc, datactl_ena, halt;
    logic [3:0] state;

    cpu_ctrl_fsm #(.HALT_STICKY(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
`ifdef CTRL_SINGLE_STEP_EN
        .step        (step),
`endif
        .opcode      (opcode),
        .zero        (zero),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .alu_en      (alu_en),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {load_ir, inc_pc, load_pc, rd, wr, alu_en, load_acc, datactl_ena, halt}
    localparam logic [8:0] N  = 9'b000000000;
    localparam logic [8:0] LI = 9'b100000000;
    localparam logic [8:0] IP = 9'b010000000;
    localparam logic [8:0] LP = 9'b001000000;
    localparam logic [8:0] RD = 9'b000100000;
    localparam logic [8:0] WR = 9'b000010000;
    localparam logic [8:0] AE = 9'b000001000;
    localparam logic [8:0] LA = 9'b000000100;
    localparam logic [8:0] DE = 9'b000000010;
    localparam logic [8:0] H  = 9'b000000001;
    localparam logic [8:0] F  = LI | IP | RD;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            logic [12:0] a;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state, load_ir, inc_pc, load_pc, rd, wr, alu_en, load_acc, datactl_ena, halt};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                         t, a[12:9], a[8:0], e[12:9], e[8:0]);
            end
        end
    end

    task automatic push(input string t, input logic [3:0] es, input logic [8:0] eo);
        exp_q.push_back({es, eo});
        tag_q.push_back(t);
    endtask

    // One clock cycle: expectation for the current cycle, then advance to posedge+1.
    task automatic cyc(input string t, input logic [3:0] es, input logic [8:0] eo);
        push(t, es, eo);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string t, input logic [2:0] op, input logic z,
                             input logic [71:0] ex);
        opcode = op;
        zero   = z;
        for (int i = 0; i < 8; i++) begin
            cyc(t, 4'(i), ex[71 - 9*i -: 9]);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        step   = 1'b1;
        opcode = 3'b000;
        zero   = 1'b0;
        @(posedge clk);
        #1;

        cyc("reset", 4'd0, N);
        rst_n = 1'b1;
        cyc("idle_ena0", 4'd0, N);
        ena = 1'b1;
        cyc("arm", 4'd0, N);

        run_instr("lda",    3'b101, 1'b0, {F, F, N, N, RD | AE, RD | LA, N, N});
        run_instr("sto",    3'b110, 1'b0, {F, F, N, N, DE, DE | WR, DE, N});
        run_instr("skz_z1", 3'b001, 1'b1, {F, F, N, N, N, IP, IP, N});
        run_instr("skz_z0", 3'b001, 1'b0, {F, F, N, N, N, N, N, N});
        run_instr("jmp",    3'b111, 1'b0, {F, F, N, N, LP, N, N, N});

        // ena dropped mid-instruction, then re-armed
        opcode = 3'b101;
        cyc("drop_s0", 4'd0, F);
        cyc("drop_s1", 4'd1, F);
        cyc("drop_s2", 4'd2, N);
        ena = 1'b0;
        cyc("drop_s3", 4'd3, N);
        cyc("drop_idle", 4'd0, N);
        ena = 1'b1;
        cyc("rearm", 4'd0, N);
        run_instr("lda_restart", 3'b101, 1'b0, {F, F, N, N, RD | AE, RD | LA, N, N});

        // reset asserted in S5 of ADD
        opcode = 3'b010;
        cyc("add_s0", 4'd0, F);
        cyc("add_s1", 4'd1, F);
        cyc("add_s2", 4'd2, N);
        cyc("add_s3", 4'd3, N);
        cyc("add_s4", 4'd4, RD | AE);
        push("add_s5", 4'd5, RD | LA);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        push("abort_s5", 4'd0, N);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("abort_rearm", 4'd0, N);
        run_instr("add", 3'b010, 1'b0, {F, F, N, N, RD | AE, RD | LA, N, N});

        // sticky HLT
        opcode = 3'b000;
        cyc("hlt_s0", 4'd0, F);
        cyc("hlt_s1", 4'd1, F);
        cyc("hlt_s2", 4'd2, N);
        cyc("hlt_s3", 4'd3, H);
        for (int i = 0; i < 20; i++) begin
            ena = i[0];
            cyc("halted", 4'd8, H);
        end
        rst_n = 1'b0;
        cyc("halt_reset", 4'd0, N);
        rst_n = 1'b1;
        ena   = 1'b0;
        cyc("post_reset", 4'd0, N);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Instruction-sequencing controller for the 8-bit accumulator CPU. It is the issuing end of the ALU/datapath control interface.
- Walks an 8-phase fetch/decode/execute cycle per instruction.
- Drives the ALU enable, PC, IR, accumulator, RAM read/write and data-bus-driver controls from the 3-bit opcode and the accumulator zero flag.
- Sits between the clock-enable generator and the datapath (PC, IR, ALU, accumulator, datactl, RAM/ROM).

Parameters:
- HALT_STICKY, 1, 1 = park in HALTED after HLT until reset; 0 = pulse halt in S3 only and keep sequencing.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  run enable; 0 forces sequencer idle
- opcode  in  3  IR opcode: HLT=000 SKZ=001 ADD=010 ANDD=011 XORR=100 LDA=101 STO=110 JMP=111
- zero  in  1  accumulator==0 flag
- load_ir  out  1  IR load strobe
- inc_pc  out  1  PC increment strobe
- load_pc  out  1  PC load (jump) strobe
- rd  out  1  memory read
- wr  out  1  memory write
- alu_en  out  1  ALU evaluate enable
- load_acc  out  1  accumulator load from ALU result
- datactl_ena  out  1  drive accumulator onto data bus
- halt  out  1  halted indication
- state  out  4  debug: current state code

Behaviour:
- State register, 4-bit encoding: S0..S7 = 0..7, HALTED = 8.
- Async reset: state=S0, active=0, all outputs 0.
- Outputs are combinational decode of state, active, opcode and zero. All outputs except halt are 0 whenever active=0.
- active register:
  - set on first posedge with ena=1;
  - cleared synchronously when ena=0, which also forces state=S0.
- With ena=1, state advances one per clk: S0→S1→…→S7→S0.
- Opcode is valid only from S2 onward (IR loaded by end of S1); decode uses it in S3–S6 only.
- Per-state outputs (unlisted = 0):
  - S0 FETCH_HI: rd, load_ir, inc_pc
  - S1 FETCH_LO: rd, load_ir, inc_pc
  - S2 IDLE: none
  - S3 DECODE: opcode=HLT → halt=1; next state HALTED if HALT_STICKY=1, else S4. All other opcodes: none.
  - S4 EXEC1: JMP → load_pc. ADD/ANDD/XORR/LDA → rd, alu_en. STO → datactl_ena. SKZ/HLT → none.
  - S5 EXEC2: ADD/ANDD/XORR/LDA → rd, load_acc (ALU result registered at end of S4). STO → datactl_ena, wr. SKZ → inc_pc=zero. JMP/HLT → none.
  - S6 EXEC3: STO → datactl_ena. SKZ → inc_pc=zero. All others: none.
  - S7 WRAP: none.
  - HALTED: halt=1, others 0, state held regardless of ena; exit only via rst_n.
- Per-instruction totals:
  - SKZ with zero=1 gives exactly 2 extra inc_pc pulses (skips one 2-byte instruction); zero=0 gives none.
  - wr is asserted only while datactl_ena=1. No cycle asserts rd and wr together.
- zero is sampled combinationally each of S5/S6; a change between S5 and S6 is honoured per cycle. The accumulator is not written by SKZ, so zero is stable in practice.
- rst_n asserted mid-instruction aborts immediately: outputs 0, state S0, no partial write.
- ena dropped mid-instruction: next edge → S0, outputs 0. Restart re-fetches from the current PC.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- When defined: adds input port step (1 bit). The FSM holds in S7 until a posedge where step=1, then moves to S0. step has no effect in other states.
- When undefined: no step port; S7→S0 unconditionally.

Test Plan:
- Reset, then ena=1 with opcode=LDA (101) → state 0,1,…,7,0. load_ir+inc_pc+rd in S0,S1; rd+alu_en in S4; rd+load_acc in S5; wr never high.
- opcode=STO (110) → datactl_ena high in S4–S6; wr high only in S5; rd low in S4–S7.
- opcode=SKZ (001), zero=1 → inc_pc high in S5 and S6. Repeat with zero=0 → inc_pc low S2–S7.
- opcode=JMP (111) → load_pc high only in S4; no rd/wr/load_acc in S2–S7.
- opcode=HLT (000), HALT_STICKY=1 → halt rises in S3, state=8 thereafter for ≥20 cycles with ena toggling. rst_n pulse → state=0, halt=0.
- rst_n asserted in S5 of ADD (010) → same-cycle outputs 0, state=0. After release, next instruction starts with FETCH_HI.
